// File: rtl/dmem_if.sv
// ---------------------------------------------------------------------------
// dmem_if -- request/response bus between the core's MEM-stage load/store
// port (master) and the data-memory responder (slave).
//
//   req_valid  master -> slave  request present
//   req_ready  slave  -> master responder can accept
//   req_write  master -> slave  1 = store, 0 = load
//   req_funct3 master -> slave  RISC-V funct3 (access width / sign)
//   req_addr   master -> slave  byte address
//   req_wdata  master -> slave  store data, right-aligned
//   rsp_valid  slave  -> master one-cycle response strobe
//   rsp_rdata  slave  -> master extended load result (0 for stores/errors)
//   rsp_err    slave  -> master access faulted, qualified by rsp_valid
// ---------------------------------------------------------------------------
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder -- data-memory responder for the pipelined RISC-V core.
//
// Serves one load/store at a time: a request is accepted in IDLE, held for
// WAIT_CYCLES cycles in WAIT, and answered with a one-cycle rsp_valid strobe
// in RESP. Byte/half/word accesses with RISC-V load extension; misaligned,
// illegal-funct3 and out-of-range accesses are flagged with rsp_err and have
// no side effect.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high; abandons any in-flight transaction
//   bus      dmem_if.slave (req_* in, req_ready/rsp_* out)
//   led_out  4-bit LED register (only when DMEM_MMIO_LED_EN is defined)
//
// Optional feature macro: DMEM_MMIO_LED_EN
//   Maps a 4-bit LED register onto the word containing byte address
//   MMIO_ADDR. Without the macro that address is ordinary (and faults if it
//   lies beyond the RAM).
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_ADDR   = 32'h0000_1000
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus
`ifdef DMEM_MMIO_LED_EN
  ,
  output logic [3:0] led_out
`endif
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  // The wait counter is 4 bits wide and must never wrap.
  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end
    if (DEPTH_WORDS < 1) begin : g_bad_depth
      $error("dmem_responder: DEPTH_WORDS must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // Right-align the addressed lane(s) and apply RISC-V load extension.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  load_extend = 32'(b);
      3'b001:  load_extend = 32'(h);
      3'b100:  load_extend = {24'b0, sh[7:0]};
      3'b101:  load_extend = {16'b0, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  store_lanes = 4'b0001 << off;
      3'b001:  store_lanes = 4'b0011 << off;
      default: store_lanes = 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data across all lanes; the lane
  // enables pick which copy lands.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      3'b000:  store_data = {4{wdata[7:0]}};
      3'b001:  store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        lat_write;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        cur_write;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic        legal_f3, misalign, in_range, is_mmio, lane_err, acc_err;
  logic        enter_resp, commit, ram_we;
  logic [IDX_W-1:0] idx;
  logic [31:0] rd_src, load_val;
  logic [3:0]  lanes;
  logic [31:0] wd_lanes;

  logic [31:0] mem [DEPTH_WORDS];

  // With WAIT_CYCLES=0 the RESP edge is the accept edge itself, so the
  // transaction is decoded from the live request while in IDLE and from the
  // latched copy afterwards.
  assign cur_write  = (state_q == S_IDLE) ? bus.req_write  : lat_write;
  assign cur_funct3 = (state_q == S_IDLE) ? bus.req_funct3 : lat_funct3;
  assign cur_addr   = (state_q == S_IDLE) ? bus.req_addr   : lat_addr;
  assign cur_wdata  = (state_q == S_IDLE) ? bus.req_wdata  : lat_wdata;

  assign legal_f3 = cur_write ? (cur_funct3 inside {3'b000, 3'b001, 3'b010})
                              : (cur_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misalign = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                    ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
  assign in_range = cur_addr[31:2] < DEPTH_W30;
  assign idx      = cur_addr[IDX_W+1:2];

`ifdef DMEM_MMIO_LED_EN
  logic [3:0] led_q;
  assign is_mmio  = cur_addr[31:2] == MMIO_ADDR[31:2];
  // The LED register only occupies lane 0; sub-word stores elsewhere fault.
  assign lane_err = is_mmio && cur_write && (cur_funct3 != 3'b010) && (cur_addr[1:0] != 2'b00);
  assign rd_src   = is_mmio ? {28'b0, led_q} : mem[idx];
  assign led_out  = led_q;
`else
  logic unused_mmio;
  assign unused_mmio = ^MMIO_ADDR;
  assign is_mmio     = 1'b0;
  assign lane_err    = 1'b0;
  assign rd_src      = mem[idx];
`endif

  assign acc_err  = !legal_f3 || misalign || !(in_range || is_mmio) || lane_err;
  assign load_val = load_extend(rd_src, cur_addr[1:0], cur_funct3);
  assign lanes    = store_lanes(cur_funct3, cur_addr[1:0]);
  assign wd_lanes = store_data(cur_funct3, cur_wdata);

  // Side effects happen only on the edge entering RESP, and reset on that
  // same edge cancels them.
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign commit     = enter_resp && !reset;
  assign ram_we     = commit && cur_write && !acc_err && !is_mmio;

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || cur_write) ? 32'd0 : load_val;
      end else begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

`ifdef DMEM_MMIO_LED_EN
  always_ff @(posedge clk) begin
    if (reset)                                        led_q <= 4'd0;
    else if (commit && cur_write && is_mmio && !acc_err) led_q <= cur_wdata[3:0];
  end
`endif

  // Request capture (data only, no reset)
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.req_valid) begin
      lat_write  <= bus.req_write;
      lat_funct3 <= bus.req_funct3;
      lat_addr   <= bus.req_addr;
      lat_wdata  <= bus.req_wdata;
    end
  end

  // Storage array (not cleared by reset)
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) mem[idx][8*b +: 8] <= wd_lanes[8*b +: 8];
      end
    end
  end

endmodule
